// File: rtl/s_chunk_loader.sv
// s_chunk_loader: packs a serial 2-bit base stream into P-base chunks (pack + hold double buffer) and returns one chunk per request
module s_chunk_loader #(
  parameter int PE_ARRAY_SIZE     = 8,
  parameter int PE_ARRAY_SIZE_LOG = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic                         i_init,
  input  logic                         i_base_valid,
  input  logic [1:0]                   i_base,
  input  logic                         i_base_last,
  output logic                         o_base_ready,
  input  logic                         i_request_s,
  output logic [2*PE_ARRAY_SIZE-1:0]   o_s,
  output logic [PE_ARRAY_SIZE_LOG:0]   o_s_valid,
  output logic                         o_s_last,
  output logic                         o_done
);
  localparam int W = 2 * PE_ARRAY_SIZE;
  localparam int C = PE_ARRAY_SIZE_LOG + 1;
  localparam logic [C-1:0] FULL = C'(PE_ARRAY_SIZE);
  localparam logic [C-1:0] FULL_M1 = C'(PE_ARRAY_SIZE - 1);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t         r_state;
  logic [W-1:0]   r_pack, r_hold, r_s;
  logic [C-1:0]   r_pack_cnt, r_hold_cnt, r_s_valid;
  logic           r_pack_closed, r_pack_last, r_hold_full, r_hold_last;
  logic           r_pend, r_s_last, r_done;
  logic           w_active, w_ready, w_accept, w_deliver, w_xfer;
  logic [W-1:0]   w_slot;
  assign w_active  = (r_state == LOAD) || (r_state == DRAIN);
  assign w_ready   = (r_state == LOAD) && (r_pack_cnt < FULL) && !r_pack_closed;
  assign w_accept  = w_ready && i_base_valid;
  // a request arriving this cycle is served immediately when the hold is full
  assign w_deliver = w_active && (r_pend || i_request_s) && r_hold_full;
  assign w_xfer    = (r_state == LOAD) && r_pack_closed && (!r_hold_full || w_deliver);
  assign w_slot    = {i_base, {(W-2){1'b0}}} >> {r_pack_cnt, 1'b0};
  assign o_base_ready = w_ready;
  assign o_s       = r_s;
  assign o_s_valid = r_s_valid;
  assign o_s_last  = r_s_last;
  assign o_done    = r_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pack        <= '0;
      r_pack_cnt    <= '0;
      r_pack_closed <= 1'b0;
      r_pack_last   <= 1'b0;
      r_hold        <= '0;
      r_hold_cnt    <= '0;
      r_hold_full   <= 1'b0;
      r_hold_last   <= 1'b0;
      r_pend        <= 1'b0;
      r_s           <= '0;
      r_s_valid     <= '0;
      r_s_last      <= 1'b0;
      r_done        <= 1'b0;
    end else if (i_init) begin
      r_state       <= IDLE;
      r_pack        <= '0;
      r_pack_cnt    <= '0;
      r_pack_closed <= 1'b0;
      r_pack_last   <= 1'b0;
      r_hold        <= '0;
      r_hold_cnt    <= '0;
      r_hold_full   <= 1'b0;
      r_hold_last   <= 1'b0;
      r_pend        <= 1'b0;
      r_s           <= '0;
      r_s_valid     <= '0;
      r_s_last      <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_s_valid <= w_deliver ? r_hold_cnt : '0;
      r_s_last  <= w_deliver && r_hold_last;
      if (w_deliver) r_s <= r_hold;
      r_pend <= w_active && (w_deliver ? (r_pend && i_request_s) : (r_pend || i_request_s));
      if (w_xfer) begin
        r_hold        <= r_pack;
        r_hold_cnt    <= r_pack_cnt;
        r_hold_last   <= r_pack_last;
        r_hold_full   <= 1'b1;
        r_pack        <= '0;
        r_pack_cnt    <= '0;
        r_pack_closed <= 1'b0;
        r_pack_last   <= 1'b0;
      end else begin
        if (w_deliver) r_hold_full <= 1'b0;
        if (w_accept) begin
          r_pack        <= r_pack | w_slot;
          r_pack_cnt    <= r_pack_cnt + C'(1);
          r_pack_closed <= (r_pack_cnt == FULL_M1) || i_base_last;
          r_pack_last   <= i_base_last;
        end
      end
      if ((r_state == IDLE || r_state == DONE) && i_start) begin
        r_state       <= LOAD;
        r_done        <= 1'b0;
        r_pack        <= '0;
        r_pack_cnt    <= '0;
        r_pack_closed <= 1'b0;
        r_pack_last   <= 1'b0;
        r_hold_full   <= 1'b0;
        r_hold_last   <= 1'b0;
        r_pend        <= 1'b0;
      end else if (w_xfer && r_pack_last) begin
        r_state <= DRAIN;
      end else if (r_state == DRAIN && w_deliver && r_hold_last) begin
        r_state <= DONE;
        r_done  <= 1'b1;
      end
    end
endmodule

// File: tb/tb_s_chunk_loader.sv
// tb_s_chunk_loader: scenario tasks plus randomized streams checked against a chunking model of the base list
module tb_s_chunk_loader;
  localparam int P = 8;
  localparam int W = 16;
  localparam int C = 4;
  logic clk = 0, rst_n = 0, i_start = 0, i_init = 0;
  logic i_base_valid = 0, i_base_last = 0, i_request_s = 0;
  logic [1:0] i_base = 0;
  logic o_base_ready, o_s_last, o_done;
  logic [W-1:0] o_s;
  logic [C-1:0] o_s_valid;
  int n_checks = 0, n_fail = 0, ncyc = 0;
  typedef struct {logic [W-1:0] d; logic [C-1:0] v; logic l; int t;} chunk_t;
  chunk_t q_got[$];
  logic [1:0] q_in[$];

  always #5 clk = ~clk;

  s_chunk_loader #(.PE_ARRAY_SIZE(P), .PE_ARRAY_SIZE_LOG(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_init(i_init),
    .i_base_valid(i_base_valid), .i_base(i_base), .i_base_last(i_base_last),
    .o_base_ready(o_base_ready), .i_request_s(i_request_s), .o_s(o_s),
    .o_s_valid(o_s_valid), .o_s_last(o_s_last), .o_done(o_done)
  );

  always @(negedge clk) begin
    ncyc++;
    if (o_s_valid != 0) q_got.push_back('{d: o_s, v: o_s_valid, l: o_s_last, t: ncyc});
  end

  function automatic logic [W-1:0] model_chunk(input int c, input int cnt);
    logic [W-1:0] e;
    e = '0;
    for (int k = 0; k < cnt; k++) e |= W'(q_in[c*P+k]) << (W - 2 - 2*k);
    return e;
  endfunction

  task automatic start_seq;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
  endtask

  task automatic send(input logic [1:0] b, input bit last);
    int k;
    bit acc;
    k = 0;
    acc = 0;
    i_base_valid = 1; i_base = b; i_base_last = last;
    while (!acc && k < 50) begin
      acc = o_base_ready;
      @(negedge clk);
      k++;
    end
    i_base_valid = 0; i_base_last = 0;
    n_checks++;
    if (!acc) begin n_fail++; $display("FAIL send_timeout: base not accepted within 50 cycles"); end
  endtask

  task automatic req_pulse;
    i_request_s = 1;
    @(negedge clk);
    i_request_s = 0;
  endtask

  task automatic run_seq(input int vprob, input int rprob, output bit to);
    int idx, cyc;
    bit acc;
    idx = 0; cyc = 0;
    start_seq();
    while (!o_done && cyc < 2000) begin
      i_base_valid = (idx < q_in.size()) && ($urandom_range(99) < vprob);
      i_base = i_base_valid ? q_in[idx] : 2'($urandom);
      i_base_last = i_base_valid && (idx == q_in.size() - 1);
      i_request_s = $urandom_range(99) < rprob;
      acc = i_base_valid && o_base_ready;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    i_base_valid = 0; i_base_last = 0; i_request_s = 0;
    to = !o_done;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_base_ready, o_s, o_s_valid, o_s_last, o_done} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got rdy=%b s=%h v=%0d l=%b d=%b, want all 0", o_base_ready, o_s, o_s_valid, o_s_last, o_done); end
    rst_n = 1;
    @(negedge clk);
    req_pulse();
    @(negedge clk);
    n_checks++;
    if (o_base_ready !== 0 || o_s_valid !== 0)
      begin n_fail++; $display("FAIL idle_ignores: got rdy=%b v=%0d, want 0 0", o_base_ready, o_s_valid); end
  endtask

  task automatic test_exact_multiple;
    bit to;
    q_in = '{0, 1, 2, 3, 0, 1, 2, 3};
    q_got.delete();
    run_seq(100, 20, to);
    n_checks++;
    if (to || q_got.size() != 1) begin
      n_fail++; $display("FAIL exact_count: got timeout=%b chunks=%0d, want 0 1", to, q_got.size());
    end else if (q_got[0].d !== 16'h1B1B || q_got[0].v !== 4'd8 || q_got[0].l !== 1'b1) begin
      n_fail++; $display("FAIL exact_chunk: got %h/%0d/%b, want 1b1b/8/1", q_got[0].d, q_got[0].v, q_got[0].l);
    end
    n_checks++;
    if (o_done !== 1) begin n_fail++; $display("FAIL exact_done: got %b, want 1", o_done); end
  endtask

  task automatic test_partial;
    start_seq();
    for (int i = 0; i < 11; i++) send(2'b11, i == 10);
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_s_valid !== 0 || o_base_ready !== 0)
      begin n_fail++; $display("FAIL partial_wait: got v=%0d rdy=%b, want 0 0", o_s_valid, o_base_ready); end
    req_pulse();
    n_checks++;
    if (o_s !== 16'hFFFF || o_s_valid !== 4'd8 || o_s_last !== 0)
      begin n_fail++; $display("FAIL partial_first: got %h/%0d/%b, want ffff/8/0", o_s, o_s_valid, o_s_last); end
    @(negedge clk);
    n_checks++;
    if (o_s_valid !== 0 || o_s !== 16'hFFFF)
      begin n_fail++; $display("FAIL partial_hold: got v=%0d s=%h, want 0 ffff", o_s_valid, o_s); end
    req_pulse();
    n_checks++;
    if (o_s !== 16'hFC00 || o_s_valid !== 4'd3 || o_s_last !== 1 || o_done !== 1)
      begin n_fail++; $display("FAIL partial_second: got %h/%0d/%b done=%b, want fc00/3/1 done=1", o_s, o_s_valid, o_s_last, o_done); end
  endtask

  task automatic test_early_request;
    logic [W-1:0] e;
    q_in.delete();
    for (int i = 0; i < P; i++) q_in.push_back(2'($urandom));
    e = model_chunk(0, P);
    start_seq();
    q_got.delete();
    i_request_s = 1;
    repeat (3) @(negedge clk);
    i_request_s = 0;
    for (int i = 0; i < P; i++) send(q_in[i], i == P - 1);
    n_checks++;
    if (o_s_valid !== 0) begin n_fail++; $display("FAIL early_n1: got v=%0d, want 0", o_s_valid); end
    @(negedge clk);
    n_checks++;
    if (o_s_valid !== 0) begin n_fail++; $display("FAIL early_n2: got v=%0d, want 0", o_s_valid); end
    @(negedge clk);
    n_checks++;
    if (o_s_valid !== 4'd8 || o_s !== e || o_s_last !== 1)
      begin n_fail++; $display("FAIL early_data: got %h/%0d/%b, want %h/8/1", o_s, o_s_valid, o_s_last, e); end
    @(negedge clk);
    n_checks++;
    if (o_s_valid !== 0) begin n_fail++; $display("FAIL early_one_cycle: got v=%0d, want 0", o_s_valid); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (q_got.size() != 1 || o_done !== 1)
      begin n_fail++; $display("FAIL early_single: got chunks=%0d done=%b, want 1 1", q_got.size(), o_done); end
  endtask

  task automatic test_back_to_back;
    int idx, k, lowc;
    bit acc;
    q_in.delete();
    for (int i = 0; i < 3*P; i++) q_in.push_back(2'($urandom));
    q_got.delete();
    start_seq();
    i_request_s = 1;
    idx = 0; k = 0; lowc = 0;
    while (idx < 3*P && k < 200) begin
      i_base_valid = 1; i_base = q_in[idx]; i_base_last = (idx == 3*P - 1);
      acc = o_base_ready;
      if (!acc && idx > 0) lowc++;
      @(negedge clk);
      if (acc) idx++;
      k++;
    end
    i_base_valid = 0; i_base_last = 0;
    repeat (4) @(negedge clk);
    i_request_s = 0;
    n_checks++;
    if (idx != 3*P || lowc != 2)
      begin n_fail++; $display("FAIL b2b_ready: got accepted=%0d low_cycles=%0d, want 24 2", idx, lowc); end
    n_checks++;
    if (q_got.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d chunks, want 3", q_got.size());
    end else begin
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (q_got[c].d !== model_chunk(c, P) || q_got[c].v !== 4'd8 || q_got[c].l !== (c == 2))
          begin n_fail++; $display("FAIL b2b_chunk%0d: got %h/%0d/%b, want %h/8/%b", c, q_got[c].d, q_got[c].v, q_got[c].l, model_chunk(c, P), c == 2); end
      end
      n_checks++;
      if (q_got[1].t - q_got[0].t != P + 1 || q_got[2].t - q_got[1].t != P + 1)
        begin n_fail++; $display("FAIL b2b_spacing: got %0d %0d, want 9 9", q_got[1].t - q_got[0].t, q_got[2].t - q_got[1].t); end
    end
    n_checks++;
    if (o_done !== 1) begin n_fail++; $display("FAIL b2b_done: got %b, want 1", o_done); end
  endtask

  task automatic test_init;
    start_seq();
    for (int i = 0; i < P; i++) send(2'($urandom_range(1, 3)), 0);
    req_pulse();
    repeat (3) @(negedge clk);
    for (int i = 0; i < P; i++) send(2'($urandom), 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) send(2'($urandom), 0);
    n_checks++;
    if (o_s === '0) begin n_fail++; $display("FAIL init_pre: got s=%h, want nonzero", o_s); end
    i_init = 1; i_request_s = 1;
    @(negedge clk);
    i_init = 0; i_request_s = 0;
    n_checks++;
    if ({o_base_ready, o_s, o_s_valid, o_s_last, o_done} !== '0)
      begin n_fail++; $display("FAIL init_clear: got rdy=%b s=%h v=%0d l=%b d=%b, want all 0", o_base_ready, o_s, o_s_valid, o_s_last, o_done); end
    req_pulse();
    @(negedge clk);
    n_checks++;
    if (o_s_valid !== 0) begin n_fail++; $display("FAIL init_idle: got v=%0d, want 0", o_s_valid); end
    q_in.delete();
    for (int i = 0; i < 3; i++) q_in.push_back(2'($urandom));
    q_got.delete();
    start_seq();
    for (int i = 0; i < 3; i++) send(q_in[i], i == 2);
    req_pulse();
    repeat (4) @(negedge clk);
    n_checks++;
    if (q_got.size() != 1) begin
      n_fail++; $display("FAIL init_restart_count: got %0d chunks, want 1", q_got.size());
    end else if (q_got[0].d !== model_chunk(0, 3) || q_got[0].v !== 4'd3 || q_got[0].l !== 1) begin
      n_fail++; $display("FAIL init_restart: got %h/%0d/%b, want %h/3/1", q_got[0].d, q_got[0].v, q_got[0].l, model_chunk(0, 3));
    end
  endtask

  task automatic test_async_reset;
    bit bad;
    start_seq();
    for (int i = 0; i < P; i++) send(2'($urandom_range(1, 3)), i == P - 1);
    repeat (2) @(negedge clk);
    req_pulse();
    n_checks++;
    if (o_s_valid !== 4'd8) begin n_fail++; $display("FAIL arst_pre: got v=%0d, want 8", o_s_valid); end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({o_base_ready, o_s, o_s_valid, o_s_last, o_done} !== '0)
      begin n_fail++; $display("FAIL arst_immediate: got rdy=%b s=%h v=%0d l=%b d=%b, want all 0", o_base_ready, o_s, o_s_valid, o_s_last, o_done); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    bad = 0;
    i_base_valid = 1; i_request_s = 1;
    for (int i = 0; i < 6; i++) begin
      i_base = 2'($urandom);
      @(negedge clk);
      if ({o_base_ready, o_s, o_s_valid, o_s_last, o_done} !== '0) bad = 1;
    end
    i_base_valid = 0; i_request_s = 0;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL arst_quiet: got output activity before start, want none"); end
  endtask

  task automatic test_random;
    int n, nch, cnt;
    bit to;
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 40);
      q_in.delete();
      for (int i = 0; i < n; i++) q_in.push_back(2'($urandom));
      q_got.delete();
      run_seq($urandom_range(30, 100), $urandom_range(10, 90), to);
      nch = (n + P - 1) / P;
      n_checks++;
      if (to || q_got.size() != nch)
        begin n_fail++; $display("FAIL rand%0d_count: got timeout=%b chunks=%0d, want 0 %0d (n=%0d)", it, to, q_got.size(), nch, n); end
      for (int c = 0; c < nch && c < q_got.size(); c++) begin
        cnt = (n - c*P < P) ? n - c*P : P;
        n_checks++;
        if (q_got[c].d !== model_chunk(c, cnt) || q_got[c].v !== C'(cnt) || q_got[c].l !== (c == nch - 1))
          begin n_fail++; $display("FAIL rand%0d_chunk%0d: got %h/%0d/%b, want %h/%0d/%b", it, c, q_got[c].d, q_got[c].v, q_got[c].l, model_chunk(c, cnt), cnt, c == nch - 1); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_exact_multiple();
    test_partial();
    test_early_request();
    test_back_to_back();
    test_init();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
